// File: rtl/mcycle_alu_if.sv
// Request/response bundle for mcycle_alu: the requester drives through the
// master modport and the ALU sits on the slave modport.
interface mcycle_alu_if #(
  parameter int WIDTH = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic [3:0]           req_op;
  logic [WIDTH-1:0]     req_a;
  logic [WIDTH-1:0]     req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [2*WIDTH-1:0]   rsp_result;
  logic                 rsp_z;
  logic                 rsp_v;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_z, rsp_v
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_z, rsp_v
  );
endinterface

// File: rtl/mcycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and
// restoring DIV (DIV only when MCYCLE_ALU_DIV_EN is defined; otherwise op 9 is reserved).
module mcycle_alu #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mcycle_alu_if.slave   bus
);
  localparam int RW  = 2 * WIDTH;
  localparam int SHW = $clog2(WIDTH) + 1;
  localparam int CW  = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LSH  = 4'd6;
  localparam logic [3:0] OP_RSH  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd8;
`ifdef MCYCLE_ALU_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'd9;
`endif

  logic [1:0]        state;
  logic [3:0]        op_q;
  logic [WIDTH-1:0]  acc_hi;
  logic [WIDTH-1:0]  acc_lo;
  logic [WIDTH-1:0]  opnd;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     result_q;
  logic              z_q;
  logic              v_q;

  assign bus.req_ready  = (state == IDLE);
  assign bus.rsp_valid  = (state == DONE);
  assign bus.rsp_result = result_q;
  assign bus.rsp_z      = z_q;
  assign bus.rsp_v      = v_q;

  // Single-cycle datapath, evaluated straight from the request inputs.
  logic [RW-1:0]  a_ext;
  logic [RW-1:0]  b_ext;
  logic [SHW-1:0] shamt;
  logic [RW-1:0]  sc_result;
  logic           sc_v;
  logic           sc_multi;

  assign a_ext = {{WIDTH{1'b0}}, bus.req_a};
  assign b_ext = {{WIDTH{1'b0}}, bus.req_b};
  assign shamt = bus.req_b[SHW-1:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value unassigned and infer a latch.
  always_comb begin
    sc_result = '0;
    sc_v      = 1'b0;
    sc_multi  = 1'b0;
    case (bus.req_op)
      OP_ADD: begin
        sc_result = a_ext + b_ext;
        sc_v      = sc_result[WIDTH];
      end
      OP_SUB: begin
        if (bus.req_a >= bus.req_b) sc_result = {{WIDTH{1'b0}}, bus.req_a - bus.req_b};
        else                        sc_v      = 1'b1;
      end
      OP_MUL:  sc_multi  = 1'b1;
`ifdef MCYCLE_ALU_DIV_EN
      OP_DIV:  sc_multi  = 1'b1;
`endif
      OP_AND:  sc_result = a_ext & b_ext;
      OP_OR:   sc_result = a_ext | b_ext;
      OP_XOR:  sc_result = a_ext ^ b_ext;
      OP_LSH: begin
        sc_result = a_ext << shamt;
        sc_v      = |sc_result[RW-1:WIDTH];
      end
      OP_RSH:  sc_result = a_ext >> shamt;
      OP_PASS: sc_result = a_ext;
      default: sc_v      = 1'b1;
    endcase
  end

  // One iteration step. MUL: {hi,lo} holds partial product with the multiplier
  // shifting out of lo. DIV: hi is the remainder, lo shifts dividend out/quotient in.
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH-1:0]  addend;
  logic [WIDTH-1:0]  step_hi;
  logic [WIDTH-1:0]  step_lo;
  logic              multi_v;
`ifdef MCYCLE_ALU_DIV_EN
  logic [WIDTH:0]    rem_sh;
  logic [WIDTH:0]    div_diff;
`endif

  always_comb begin
    addend  = acc_lo[0] ? opnd : '0;
    mul_sum = {1'b0, acc_hi} + {1'b0, addend};
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    multi_v = |step_hi;
`ifdef MCYCLE_ALU_DIV_EN
    rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = rem_sh - {1'b0, opnd};
    if (op_q == OP_DIV) begin
      // A zero divisor never borrows, so quotient saturates to all ones and
      // the dividend shifts whole into the remainder.
      step_hi = div_diff[WIDTH] ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
      multi_v = ~|opnd;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      cnt      <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q <= bus.req_op;
            cnt  <= '0;
            if (sc_multi) begin
              state  <= BUSY;
              acc_hi <= '0;
              if (bus.req_op == OP_MUL) begin
                acc_lo <= bus.req_b;
                opnd   <= bus.req_a;
              end else begin
                acc_lo <= bus.req_a;
                opnd   <= bus.req_b;
              end
            end else begin
              state    <= DONE;
              result_q <= sc_result;
              z_q      <= ~|sc_result[WIDTH-1:0];
              v_q      <= sc_v;
            end
          end
        end
        BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state    <= DONE;
            result_q <= {step_hi, step_lo};
            z_q      <= ~|step_lo;
            v_q      <= multi_v;
          end
        end
        DONE: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
